// File: rtl/th_fnd_display_pkg.sv
// th_fnd_display_pkg: shared FSM encodings, scan default, segment codes and BCD helpers.
package th_fnd_display_pkg;
  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    SHIFT_T = 4'b0010,
    SHIFT_H = 4'b0100,
    COMMIT  = 4'b1000
  } state_e;
  localparam int SCAN_DIV_DEF = 100_000;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  function automatic logic [6:0] clamp99(input logic [7:0] v);
    return v > 8'd99 ? 7'd99 : v[6:0];
  endfunction
  // One double-dabble step on {tens, ones, binary}: adjust nibbles >= 5, then shift left.
  function automatic logic [15:0] dd_step(input logic [15:0] v);
    logic [3:0] hi, lo;
    hi = v[15:12] >= 4'd5 ? v[15:12] + 4'd3 : v[15:12];
    lo = v[11:8] >= 4'd5 ? v[11:8] + 4'd3 : v[11:8];
    return {hi, lo, v[7:0]} << 1;
  endfunction
endpackage

// File: rtl/th_fnd_display_seg_decoder.sv
// seg_decoder: BCD digit to active-low 7-segment pattern, codes above 9 blank.
module seg_decoder
  import th_fnd_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/th_fnd_display.sv
// th_fnd_display: DHT11 temperature/humidity to 4-digit multiplexed 7-segment display.
module th_fnd_display
  import th_fnd_display_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [7:0] humidity,
  input  logic [7:0] temperature,
  output logic [7:0] seg_7,
  output logic [3:0] com,
  output logic       busy
);
  localparam int SW = $clog2(SCAN_DIV);
  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [6:0]      t_snap_q, t_snap_d, h_snap_q, h_snap_d, t_in, h_in;
  logic [15:0]     sr_q, sr_d, sh;
  logic [7:0]      t_bcd_q, t_bcd_d;
  logic            commit_q, commit_d, busy_q, busy_d, last, wrap;
  logic [3:0][3:0] dig_q, dig_d;
  logic [SW-1:0]   scan_q, scan_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      com_q, com_d;
  logic [7:0]      seg_q, seg_d;
  logic [6:0]      seg_raw;
  // One converter serves both values: temperature first, then humidity reloads the shifter.
  always_comb begin
    t_in = clamp99(temperature);
    h_in = clamp99(humidity);
    sh = dd_step(sr_q);
    last = cnt_q == 3'd7;
    state_d = state_q;
    cnt_d = cnt_q;
    sr_d = sr_q;
    t_snap_d = t_snap_q;
    h_snap_d = h_snap_q;
    t_bcd_d = t_bcd_q;
    case (state_q)
      IDLE: if ({t_in, h_in} != {t_snap_q, h_snap_q}) begin
        t_snap_d = t_in;
        h_snap_d = h_in;
        sr_d = {9'd0, t_in};
        cnt_d = 3'd0;
        state_d = SHIFT_T;
      end
      SHIFT_T: begin
        cnt_d = cnt_q + 3'd1;
        sr_d = last ? {9'd0, h_snap_q} : sh;
        t_bcd_d = last ? sh[15:8] : t_bcd_q;
        state_d = last ? SHIFT_H : SHIFT_T;
      end
      SHIFT_H: begin
        cnt_d = cnt_q + 3'd1;
        sr_d = sh;
        state_d = last ? COMMIT : SHIFT_H;
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_q != IDLE;
    commit_d = state_q == COMMIT;
    dig_d = commit_q ? {t_bcd_q, sr_q[15:8]} : dig_q;
  end
  seg_decoder u_dec (.bcd(dig_q[idx_q]), .seg(seg_raw));
  // The digit shown on a wrap is the current index; the index then steps to the next digit.
  always_comb begin
    wrap = scan_q == SW'(SCAN_DIV - 1);
    scan_d = wrap ? '0 : scan_q + 1'b1;
    idx_d = wrap ? idx_q - 2'd1 : idx_q;
    com_d = wrap ? ~(4'b0001 << idx_q) : com_q;
    seg_d = wrap ? {idx_q != 2'd2, seg_raw} : seg_q;
  end
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sr_q <= '0;
      t_snap_q <= '0;
      h_snap_q <= '0;
      t_bcd_q <= '0;
      commit_q <= 1'b0;
      busy_q <= 1'b0;
      dig_q <= '0;
      scan_q <= '0;
      idx_q <= 2'd3;
      com_q <= 4'hF;
      seg_q <= 8'hFF;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      t_snap_q <= t_snap_d;
      h_snap_q <= h_snap_d;
      t_bcd_q <= t_bcd_d;
      commit_q <= commit_d;
      busy_q <= busy_d;
      dig_q <= dig_d;
      scan_q <= scan_d;
      idx_q <= idx_d;
      com_q <= com_d;
      seg_q <= seg_d;
    end
  end
  assign seg_7 = seg_q;
  assign com = com_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_th_fnd_display.sv
// tb_th_fnd_display: scoreboard bench, expected displays queued by stimulus and checked by a monitor.
module tb_th_fnd_display;
  logic       clk = 1'b0;
  logic       reset_p = 1'b0;
  logic [7:0] humidity = 8'd0;
  logic [7:0] temperature = 8'd0;
  logic [7:0] seg_7;
  logic [3:0] com;
  logic       busy;
  int n_chk = 0;
  int n_fail = 0;
  logic [13:0] exp_q[$];
  logic [6:0]  mt = 7'd0;
  logic [6:0]  mh = 7'd0;
  localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  th_fnd_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset_p(reset_p), .humidity(humidity), .temperature(temperature),
    .seg_7(seg_7), .com(com), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] clamp(input logic [7:0] v);
    return v > 8'd99 ? 7'd99 : v[6:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A new conversion is expected whenever the clamped pair differs from the last expected one.
  task automatic drive(input logic [7:0] t, input logic [7:0] h);
    temperature = t;
    humidity = h;
    if ({clamp(t), clamp(h)} != {mt, mh}) begin
      mt = clamp(t);
      mh = clamp(h);
      exp_q.push_back({mt, mh});
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      tick(1);
    end
    check("drain", exp_q.size(), 0);
    tick(20);
  endtask

  task automatic do_reset();
    reset_p = 1'b1;
    exp_q.delete();
    mt = 7'd0;
    mh = 7'd0;
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_com", com, 4'hF);
    check("rst_seg", seg_7, 8'hFF);
    reset_p = 1'b0;
    drive(temperature, humidity);
    tick(4);
    check("first_com", com, 4'b0111);
    check("first_seg", seg_7, 8'hC0);
  endtask

  // Monitor: checks every displayed digit against the currently expected values and pops on commit.
  initial begin
    logic [3:0]  pc = 4'hF;
    logic [3:0]  ec;
    logic [7:0]  es;
    logic [6:0]  ct = 7'd0;
    logic [6:0]  ch = 7'd0;
    logic [13:0] e;
    logic        pb = 1'b0;
    int hold = -1000;
    int bcnt = 0;
    int idx = 3;
    int dig;
    forever begin
      @(negedge clk);
      if (reset_p) begin
        pc = 4'hF; pb = 1'b0; hold = -1000; bcnt = 0; idx = 3; ct = 7'd0; ch = 7'd0;
      end else begin
        hold++;
        if (com !== pc) begin
          ec = ~(4'b0001 << idx);
          check("com_seq", com, ec);
          if (hold > 0) check("com_hold", hold, 4);
          dig = idx == 3 ? ct / 10 : idx == 2 ? ct % 10 : idx == 1 ? ch / 10 : ch % 10;
          es = {idx != 2, SEG[dig]};
          check("seg", seg_7, es);
          hold = 0;
          pc = com;
          idx = (idx + 3) % 4;
        end
        if (busy) bcnt++;
        if (pb && !busy) begin
          check("busy_len", bcnt, 17);
          check("commit_pending", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ct = e[13:7];
            ch = e[6:0];
          end
          bcnt = 0;
        end
        pb = busy;
      end
    end
  end

  initial begin
    #2;
    do_reset();
    tick(36);
    drive(8'd27, 8'd45);
    wait_idle();
    drive(8'd150, 8'd200);
    wait_idle();
    drive(8'd27, 8'd45);
    tick(5);
    drive(8'd27, 8'd60);
    wait_idle();
    drive(8'd33, 8'd12);
    tick(10);
    do_reset();
    wait_idle();
    for (int r = 0; r < 10; r++) begin
      drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      if (r % 2 == 1) begin
        tick(1 + $urandom_range(1, 14));
        drive(temperature, 8'($urandom_range(0, 120)));
      end
      wait_idle();
    end
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
